// File: rtl/qeciphy_tx_framer_if.sv
// User-side valid/ready stream into the TX framer.
// 64-bit beats, one per clock when accepted.
interface qeciphy_tx_framer_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/qeciphy_tx_framer.sv
// TX framer: inserts a FAW at slot 0 of every frame, fills gaps with IDLE.
// Training mode sends FAW-only frames until train_i drops at a boundary.
module qeciphy_tx_framer #(
  parameter int          FAW_PERIOD = 64,
  parameter logic [63:0] IDLE_WORD  = 64'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   train_i,
  qeciphy_tx_framer_if.slave     s,
  output logic [63:0]            tdata_64b_o,
  output logic                   tdata_64b_isfaw_o,
  output logic                   idle_o,
  output logic [7:0]             faw_seq_o
);

  localparam int CW = $clog2(FAW_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(FAW_PERIOD - 1);

  typedef enum logic {
    TRAIN,
    DATA
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] slot_q, slot_d;
  logic [7:0]    seq_q, seq_d;
  logic [63:0]   tdata_q, tdata_d;
  logic          isfaw_q, isfaw_d;
  logic          idle_q, idle_d;
  logic [7:0]    fseq_q, fseq_d;

  logic slot0;
  logic last;
  logic ready;
  logic accept;

  assign slot0  = (slot_q == '0);
  assign last   = (slot_q == LAST);
  // Ready depends on registers only, so no input reaches it.
  assign ready  = (state_q == DATA) && !slot0;
  assign accept = s.tvalid && ready;

  assign s.tready          = ready;
  assign tdata_64b_o       = tdata_q;
  assign tdata_64b_isfaw_o = isfaw_q;
  assign idle_o            = idle_q;
  assign faw_seq_o         = fseq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TRAIN;
      slot_q  <= '0;
      seq_q   <= '0;
      tdata_q <= '0;
      isfaw_q <= 1'b0;
      idle_q  <= 1'b1;
      fseq_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      seq_q   <= seq_d;
      tdata_q <= tdata_d;
      isfaw_q <= isfaw_d;
      idle_q  <= idle_d;
      fseq_q  <= fseq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = last ? '0 : slot_q + 1'b1;
    seq_d   = seq_q;
    tdata_d = IDLE_WORD;
    isfaw_d = 1'b0;
    idle_d  = 1'b1;
    fseq_d  = fseq_q;

    unique case (state_q)
      TRAIN: if (!train_i && last) state_d = DATA;
      DATA:  if (train_i)          state_d = TRAIN;
      default: state_d = TRAIN;
    endcase

    unique case (1'b1)
      slot0: begin
        tdata_d = {48'hF0F0_3C3C_A5A5, seq_q, 8'hBC};
        isfaw_d = 1'b1;
        idle_d  = 1'b0;
        fseq_d  = seq_q;
        seq_d   = seq_q + 8'd1;
      end
      accept: begin
        tdata_d = s.tdata;
        idle_d  = 1'b0;
      end
      default: begin
        tdata_d = IDLE_WORD;
      end
    endcase
  end

endmodule
